// File: rtl/rdpiano_env_pkg.sv
// rdpiano_env_pkg
// Shared definitions for the per-voice envelope accumulator: phase encoding,
// default widths, the full-scale level constant and the target-to-threshold
// shift.
package rdpiano_env_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;

    localparam int LEVEL_W_DEF  = 19;
    localparam int TARGET_W_DEF = 13;
    // Target is aligned to the top bits of the level: thr = {target, 6'b0}.
    localparam int THR_SHIFT    = 6;

    localparam logic [LEVEL_W_DEF-1:0] ENV_MAX = '1;

endpackage

// File: rtl/rdpiano_env_step_alu.sv
// rdpiano_env_step_alu
// Combinational next-state for one voice slot.
// Ports:
//   phase_i / level_i    - stored phase and level of the voice being serviced
//   step_i / target_i    - decoded step magnitude and decay/sustain target
//   pend_i / pend_on_i   - pending key event flag and its type (1 = key-on)
//   next_phase_o / next_level_o - values written back and reported
module rdpiano_env_step_alu
    import rdpiano_env_pkg::*;
#(
    parameter int LEVEL_W  = LEVEL_W_DEF,
    parameter int TARGET_W = TARGET_W_DEF
) (
    input  logic [2:0]          phase_i,
    input  logic [LEVEL_W-1:0]  level_i,
    input  logic [LEVEL_W-1:0]  step_i,
    input  logic [TARGET_W-1:0] target_i,
    input  logic                pend_i,
    input  logic                pend_on_i,
    output logic [2:0]          next_phase_o,
    output logic [LEVEL_W-1:0]  next_level_o
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

    logic [LEVEL_W-1:0] thr;
    logic [LEVEL_W:0]   sum;
    logic [LEVEL_W:0]   diff;
    logic               key_off_live;

    assign thr  = {target_i, {THR_SHIFT{1'b0}}};
    // One extra bit so the carry/borrow lands in the MSB.
    assign sum  = {1'b0, level_i} + {1'b0, step_i};
    assign diff = {1'b0, level_i} - {1'b0, step_i};

    // Key-off only matters while the note is sounding; in IDLE/RELEASE it is
    // dropped and the slot integrates as usual.
    assign key_off_live = pend_i && !pend_on_i &&
                          (phase_i == PH_ATTACK || phase_i == PH_DECAY ||
                           phase_i == PH_SUSTAIN);

    always_comb begin
        next_phase_o = PH_IDLE;
        next_level_o = '0;
        if (pend_i && pend_on_i) begin
            // Retrigger from the current level.
            next_phase_o = PH_ATTACK;
            next_level_o = level_i;
        end else if (key_off_live) begin
            next_phase_o = PH_RELEASE;
            next_level_o = level_i;
        end else begin
            case (phase_i)
                PH_ATTACK: begin
                    if (sum[LEVEL_W] || sum[LEVEL_W-1:0] == LVL_MAX) begin
                        next_phase_o = PH_DECAY;
                        next_level_o = LVL_MAX;
                    end else begin
                        next_phase_o = PH_ATTACK;
                        next_level_o = sum[LEVEL_W-1:0];
                    end
                end
                PH_DECAY: begin
                    // Also fires with step 0 when the level already sits at
                    // or below the threshold.
                    if (diff[LEVEL_W] || diff[LEVEL_W-1:0] <= thr) begin
                        next_phase_o = PH_SUSTAIN;
                        next_level_o = thr;
                    end else begin
                        next_phase_o = PH_DECAY;
                        next_level_o = diff[LEVEL_W-1:0];
                    end
                end
                PH_SUSTAIN: begin
                    next_phase_o = PH_SUSTAIN;
                    next_level_o = level_i;
                end
                PH_RELEASE: begin
                    if (diff[LEVEL_W] || diff[LEVEL_W-1:0] == '0) begin
                        next_phase_o = PH_IDLE;
                        next_level_o = '0;
                    end else begin
                        next_phase_o = PH_RELEASE;
                        next_level_o = diff[LEVEL_W-1:0];
                    end
                end
                default: begin
                    // IDLE and unused codes 5-7: silent.
                    next_phase_o = PH_IDLE;
                    next_level_o = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rdpiano_env_accum.sv
// rdpiano_env_accum
// Time-multiplexed per-voice envelope accumulator. Each step_valid services
// the voice in the current slot: its stored phase/level plus any pending key
// event go through the step ALU, the result is written back and reported one
// cycle later.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   step_valid, step, target   - decoder output for the current slot
//   key_valid/voice/on, key_ready - key event handshake (one pending per voice)
//   env_valid/voice/level/phase - registered result of the serviced slot
//   frame_sync                 - marks the voice-0 result
module rdpiano_env_accum
    import rdpiano_env_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int LEVEL_W    = LEVEL_W_DEF,
    parameter int TARGET_W   = TARGET_W_DEF,
    localparam int VOICE_W   = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_valid,
    input  logic [LEVEL_W-1:0]  step,
    input  logic [TARGET_W-1:0] target,
    input  logic                key_valid,
    input  logic [VOICE_W-1:0]  key_voice,
    input  logic                key_on,
    output logic                key_ready,
    output logic                env_valid,
    output logic [VOICE_W-1:0]  env_voice,
    output logic [LEVEL_W-1:0]  env_level,
    output logic [2:0]          env_phase,
    output logic                frame_sync
);

    logic [VOICE_W-1:0]    slot_q, slot_d;
    logic [LEVEL_W-1:0]    level_q [NUM_VOICES];
    logic [2:0]            phase_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] pend_q;
    logic [NUM_VOICES-1:0] pend_on_q;

    logic                  env_valid_q, frame_sync_q;
    logic [VOICE_W-1:0]    env_voice_q;
    logic [LEVEL_W-1:0]    env_level_q;
    logic [2:0]            env_phase_q;

    logic [2:0]            nxt_phase;
    logic [LEVEL_W-1:0]    nxt_level;
    logic                  key_accept;

    assign slot_d     = slot_q + 1'b1;   // power-of-2 voice count wraps for free
    assign key_ready  = ~pend_q[key_voice];
    assign key_accept = key_valid & key_ready;

    rdpiano_env_step_alu #(
        .LEVEL_W  (LEVEL_W),
        .TARGET_W (TARGET_W)
    ) u_alu (
        .phase_i      (phase_q[slot_q]),
        .level_i      (level_q[slot_q]),
        .step_i       (step),
        .target_i     (target),
        .pend_i       (pend_q[slot_q]),
        .pend_on_i    (pend_on_q[slot_q]),
        .next_phase_o (nxt_phase),
        .next_level_o (nxt_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            pend_q       <= '0;
            pend_on_q    <= '0;
            env_valid_q  <= 1'b0;
            frame_sync_q <= 1'b0;
            env_voice_q  <= '0;
            env_level_q  <= '0;
            env_phase_q  <= PH_IDLE;
            for (int i = 0; i < NUM_VOICES; i++) begin
                level_q[i] <= '0;
                phase_q[i] <= PH_IDLE;
            end
        end else begin
            env_valid_q  <= step_valid;
            frame_sync_q <= step_valid && (slot_q == '0);
            if (step_valid) begin
                level_q[slot_q] <= nxt_level;
                phase_q[slot_q] <= nxt_phase;
                env_voice_q     <= slot_q;
                env_level_q     <= nxt_level;
                env_phase_q     <= nxt_phase;
                pend_q[slot_q]  <= 1'b0;
                slot_q          <= slot_d;
            end
            // Placed after the service clear: an event accepted on its own
            // voice's service cycle survives into the next frame.
            if (key_accept) begin
                pend_q[key_voice]    <= 1'b1;
                pend_on_q[key_voice] <= key_on;
            end
        end
    end

    assign env_valid  = env_valid_q;
    assign env_voice  = env_voice_q;
    assign env_level  = env_level_q;
    assign env_phase  = env_phase_q;
    assign frame_sync = frame_sync_q;

endmodule

// File: doc/rdpiano_env_accum.md
Name: rdpiano_env_accum

Overview:
- Per-voice envelope accumulator, directly downstream of the IC9 envelope step decoder.
- Consumes the 19-bit decoded step (adder1_a) and a 13-bit target for the voice slot currently being serviced.
- Runs a per-voice ADSR-style phase machine and integrates the step into a 19-bit level.
- Voices are time-multiplexed; the level output feeds the amplitude multiplier stage.

Parameters:
- NUM_VOICES, 16, voices serviced per frame (power of 2).
- LEVEL_W, 19, envelope level / step width.
- TARGET_W, 13, target width; target is compared against level[LEVEL_W-1:LEVEL_W-TARGET_W].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- step_valid  in  1  step/target valid for the current slot; advances the slot counter.
- step  in  LEVEL_W  unsigned step magnitude from the decoder.
- target  in  TARGET_W  decay/sustain target for the current slot.
- key_valid  in  1  key event offered.
- key_voice  in  log2(NUM_VOICES)  event voice.
- key_on  in  1  1 = key-on, 0 = key-off.
- key_ready  out  1  event accepted when key_valid && key_ready.
- env_valid  out  1  registered result valid.
- env_voice  out  log2(NUM_VOICES)  voice of the result.
- env_level  out  LEVEL_W  updated level.
- env_phase  out  3  updated phase.
- frame_sync  out  1  high with env_valid when env_voice == 0.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: all levels 0, all phases IDLE, pending events cleared, slot = 0, all registered outputs 0. A reset mid-frame discards all in-flight state.
- Slot counter increments on step_valid and wraps from NUM_VOICES-1 to 0. With step_valid low: no state change and env_valid = 0 the next cycle.
- Latency: outputs are registered 1 cycle after the step_valid cycle. Per-voice storage is read and written in that same cycle (no read-after-write hazard, since each slot is visited once per frame).
- Phases: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5-7 behave as IDLE.
- thr = {target, 6'b0}. MAX = 2^LEVEL_W - 1. Sum/difference is computed LEVEL_W+1 wide to detect carry/borrow.
- Pending key-on: next phase = ATTACK. Level is kept (retrigger from the current level). No accumulation this slot.
- Pending key-off:
  - In ATTACK, DECAY or SUSTAIN: next phase = RELEASE, no accumulation this slot.
  - In IDLE or RELEASE: discarded.
- ATTACK: level += step. On carry or result == MAX, level = MAX and phase = DECAY.
- DECAY: level -= step. On borrow or result <= thr, level = thr and phase = SUSTAIN.
- SUSTAIN: hold.
- RELEASE: level -= step. On borrow or result == 0, level = 0 and phase = IDLE.
- IDLE: level forced to 0.
- step == 0 holds the level. Clamp checks still apply, so DECAY with level <= thr moves to SUSTAIN.
- Key handshake:
  - One pending flag + type bit per voice.
  - key_ready = ~pending[key_voice] (combinational); high after reset.
  - The pending flag clears when that voice's slot is serviced.
  - If an event is accepted in the same cycle its voice is serviced, the service uses the old pending state and the event applies in the next frame.
  - A second event for a voice with a pending event is stalled (ready low); it is never dropped.

Decomposition:
- rdpiano_env_pkg: phase enum, LEVEL_W/TARGET_W defaults, MAX constant, thr shift (6).
- One sub-module, rdpiano_env_step_alu: combinational (phase, level, step, target, pending, pending_type) -> (next_phase, next_level).
- Top level holds the slot counter, per-voice level/phase arrays (register file, RAM-inferable), pending flags and output registers.

Test Plan:
- Reset, then a full frame of step_valid -> 16 results; env_level = 0 and phase IDLE for every voice; frame_sync only on voice 0; key_ready = 1.
- Key-on voice 3, step = 0x10000 every frame:
  - Frame 1: ATTACK, level 0.
  - Frames 2-8: 0x10000 ... 0x70000.
  - Frame 9: 0x7FFFF, phase DECAY.
- Voice 3 in DECAY from 0x7FFFF, step = 0x08000, target = 0x1000 (thr 0x40000): 0x77FFF, 0x6FFFF ... 0x47FFF, then clamp to 0x40000 with phase SUSTAIN on the 8th decay frame; held thereafter.
- Key-off voice 3 in SUSTAIN, step = 0x40000: RELEASE, level 0x40000; next frame level 0, phase IDLE. Key-off to an IDLE voice: no change, pending cleared.
- Two back-to-back events for voice 5 -> first accepted; key_ready low for voice 5 until its slot is serviced, then the second is accepted. Voice 6 events are accepted meanwhile. An event accepted on voice 5's own service cycle takes effect one frame later.
- rst asserted mid-ATTACK (voice 2 level 0x30000) -> next cycle all outputs 0. The following frame reports voice 2 level 0, phase IDLE, and no pending events.
